sin_phase_sequencer: RTL and testbench



---
 rtl/sin_phase_sequencer.sv | 112 +++++++++++
 tb/tb_sin_phase_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sin_phase_sequencer.sv
// rtl/sin_phase_sequencer.sv - phase-accumulator sequencer driving a quarter-wave sine ROM
// Folds phase into quadrant/index, reads the ROM, and rebuilds a signed full-wave sample.
module sin_phase_sequencer #(
  parameter int NBIT_FREQ  = 7,
  parameter int NBIT_PHASE = 12,
  parameter int NBIT_AMPL  = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic [NBIT_FREQ-1:0] freq,
  input  logic                 sample_tick,
  output logic                 busy,
  output logic                 rom_en,
  output logic [5:0]           rom_addr,
  input  logic [NBIT_AMPL-1:0] rom_data,
  output logic [6:0]           sample,
  output logic                 sample_valid
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                 state, state_next;
  logic [NBIT_PHASE-1:0]  phase, phase_next;
  logic [NBIT_FREQ-1:0]   freq_q, freq_q_next;
  logic [NBIT_PHASE:0]    sum;
  logic                   issue;
  logic [1:0]             quad;
  logic [4:0]             idx;
  logic [4:0]             addr;
  logic                   neg_rd;
  logic                   neg_data;
  logic                   rd_valid;
  logic [6:0]             mag;
  logic                   unused_rom_bits;

  assign sum  = {1'b0, phase} + (NBIT_PHASE+1)'(freq_q);
  assign quad = phase[NBIT_PHASE-1 -: 2];
  assign idx  = phase[NBIT_PHASE-3 -: 5];
  // Odd quadrants walk the quarter table backwards: 31-i is the bitwise inverse.
  assign addr = quad[0] ? ~idx : idx;
  assign mag  = {2'b00, rom_data[4:0]};
  assign unused_rom_bits = ^rom_data[NBIT_AMPL-1:5];

  always_comb begin
    state_next  = state;
    phase_next  = phase;
    freq_q_next = freq_q;
    issue       = 1'b0;
    case (state)
      IDLE: begin
        if (start && (freq != '0) && !stop) begin
          state_next  = RUN;
          freq_q_next = freq;
          phase_next  = '0;
        end
      end
      RUN: begin
        if (sample_tick) begin
          issue      = 1'b1;
          phase_next = sum[NBIT_PHASE-1:0];
        end
        if (stop) state_next = DRAIN;
      end
      DRAIN: begin
        // The wrapping tick is the zero crossing: stop there without a read.
        if (sample_tick) begin
          if (sum[NBIT_PHASE]) begin
            phase_next = '0;
            state_next = IDLE;
          end else begin
            issue      = 1'b1;
            phase_next = sum[NBIT_PHASE-1:0];
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      phase        <= '0;
      freq_q       <= '0;
      busy         <= 1'b0;
      rom_en       <= 1'b0;
      rom_addr     <= '0;
      neg_rd       <= 1'b0;
      neg_data     <= 1'b0;
      rd_valid     <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      state        <= state_next;
      phase        <= phase_next;
      freq_q       <= freq_q_next;
      busy         <= (state_next != IDLE);
      rom_en       <= issue;
      if (issue) begin
        rom_addr <= {1'b0, addr};
        neg_rd   <= quad[1];
      end
      rd_valid     <= rom_en;
      neg_data     <= neg_rd;
      sample_valid <= rd_valid;
      if (rd_valid) sample <= neg_data ? (7'd0 - mag) : mag;
    end
  end

endmodule

// File: tb/tb_sin_phase_sequencer.sv
// tb/tb_sin_phase_sequencer.sv - scoreboard bench for sin_phase_sequencer
module tb_sin_phase_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, stop, sample_tick;
  logic [6:0] freq;
  logic       busy, rom_en, sample_valid;
  logic [5:0] rom_addr;
  logic [5:0] rom_data = '0;
  logic [6:0] sample;

  sin_phase_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .freq(freq),
    .sample_tick(sample_tick), .busy(busy), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .sample(sample), .sample_valid(sample_valid)
  );

  always #5 clk = ~clk;

  // round(31*sin(pi/2 * i/31))
  int rom_tab [32] = '{0, 2, 3, 5, 6, 8, 9, 11, 12, 14, 15, 16, 18, 19, 20, 21,
                       22, 24, 25, 25, 26, 27, 28, 28, 29, 30, 30, 30, 31, 31, 31, 31};

  // Bit 5 of the ROM word is noise the DUT must ignore.
  always @(posedge clk)
    if (rom_en) rom_data <= {1'($urandom % 2), 5'(rom_tab[rom_addr[4:0]])};

  typedef struct { int due; int val; } exp_t;
  exp_t sbq [$];
  exp_t e;
  int   rec [$];
  bit   rec_en = 0;
  int   checks = 0, errors = 0;
  int   cyc = 0, valid_cnt = 0;
  int   m_state = 0, m_phase = 0, m_fq = 0, m_addr = 0, m_last = 0;
  bit   m_rom_en = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: phase/32 is a 0..127 position in the full wave.
  task automatic model_issue(input int p);
    int k, h, a;
    k = p / 32;
    h = k % 64;
    a = (h < 32) ? h : 63 - h;
    m_rom_en = 1;
    m_addr   = a;
    sbq.push_back('{due: cyc + 2, val: (k >= 64) ? -rom_tab[a] : rom_tab[a]});
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    m_rom_en = 0;
    if (rst) begin
      m_state = 0; m_phase = 0; m_fq = 0; m_addr = 0; m_last = 0;
      sbq.delete();
    end else begin
      case (m_state)
        0: if (start && freq != 0 && !stop) begin
             m_state = 1; m_fq = int'(freq); m_phase = 0;
           end
        1: begin
             if (sample_tick) begin
               model_issue(m_phase);
               m_phase = (m_phase + m_fq) % 4096;
             end
             if (stop) m_state = 2;
           end
        default: if (sample_tick) begin
             if (m_phase + m_fq >= 4096) begin
               m_phase = 0; m_state = 0;
             end else begin
               model_issue(m_phase);
               m_phase = m_phase + m_fq;
             end
           end
      endcase
    end
  end

  initial forever begin
    @(negedge clk);
    if (cyc >= 1) begin
      chk("busy", int'(busy), int'(m_state != 0));
      chk("rom_en", int'(rom_en), int'(m_rom_en));
      if (m_rom_en) chk("rom_addr", int'(rom_addr), m_addr);
      while (sbq.size() > 0 && sbq[0].due < cyc) begin
        chk("sample_missing", cyc, sbq[0].due);
        void'(sbq.pop_front());
      end
      if (sample_valid) begin
        valid_cnt++;
        if (rec_en) rec.push_back(int'($signed(sample)));
        if (sbq.size() == 0) chk("unexpected_sample_valid", 1, 0);
        else begin
          e = sbq.pop_front();
          chk("sample_time", cyc, e.due);
          chk("sample_value", int'($signed(sample)), e.val);
          m_last = e.val;
        end
      end
      chk("sample_hold", int'($signed(sample)), m_last);
    end
  end

  task automatic drive(input logic r, input logic s, input logic p, input logic t,
                       input logic [6:0] f);
    rst = r; start = s; stop = p; sample_tick = t; freq = f;
    @(negedge clk);
  endtask

  task automatic drain_to_idle();
    int n;
    n = 0;
    while (busy && n < 5000) begin
      drive(0, 0, 0, 1, 7'd1);
      n++;
    end
    chk("drain_timeout", int'(busy), 0);
    repeat (4) drive(0, 0, 0, 0, 7'd0);
  endtask

  initial begin
    int n, vc0;
    rst = 1; start = 1; stop = 0; sample_tick = 0; freq = 7'd5;
    repeat (3) @(negedge clk);
    chk("rst_sample", int'(sample), 0);
    chk("rst_sample_valid", int'(sample_valid), 0);
    chk("rst_rom_en", int'(rom_en), 0);
    chk("rst_rom_addr", int'(rom_addr), 0);
    chk("rst_busy", int'(busy), 0);
    drive(0, 0, 0, 0, 7'd5);
    chk("post_rst_idle", int'(busy), 0);

    // Full period at freq=32, one tick per cycle.
    drive(0, 1, 0, 0, 7'd32);
    rec_en = 1;
    repeat (130) drive(0, 0, 0, 1, 7'd32);
    repeat (4) drive(0, 0, 0, 0, 7'd32);
    rec_en = 0;
    chk("period_count", rec.size(), 130);
    if (rec.size() >= 130) begin
      chk("tick0", rec[0], 0);
      chk("tick1", rec[1], 2);
      chk("tick3", rec[3], 5);
      chk("tick31", rec[31], 31);
      chk("tick32", rec[32], 31);
      chk("tick36", rec[36], 30);
      chk("tick64", rec[64], 0);
      chk("tick65", rec[65], -2);
      chk("tick96", rec[96], -31);
      chk("tick128", rec[128], 0);
    end
    drive(0, 0, 1, 1, 7'd0);
    drain_to_idle();

    // Sparse ticks at the largest step.
    drive(0, 1, 0, 0, 7'd127);
    for (int i = 0; i < 40; i++) begin
      drive(0, 0, 0, 1, 7'd0);
      repeat (3) drive(0, 0, 0, 0, 7'd0);
    end
    drive(0, 0, 1, 0, 7'd0);
    drain_to_idle();

    // Stop at phase 0x500, finish at the 0xFE0 -> 0x000 wrap.
    drive(0, 1, 0, 0, 7'd32);
    n = 0;
    while (m_phase != 'h500 && n < 200) begin
      drive(0, 0, 0, 1, 7'd0);
      n++;
    end
    chk("reach_0x500", m_phase, 'h500);
    drive(0, 0, 1, 1, 7'd0);
    drain_to_idle();
    chk("drain_last_sample", int'($signed(sample)), -2);
    chk("drain_busy", int'(busy), 0);

    // Corner inputs in IDLE and RUN.
    drive(0, 1, 0, 0, 7'd0);
    chk("start_freq0", int'(busy), 0);
    drive(0, 1, 1, 0, 7'd9);
    chk("start_with_stop", int'(busy), 0);
    drive(0, 0, 1, 0, 7'd9);
    chk("stop_in_idle", int'(busy), 0);
    drive(0, 1, 0, 0, 7'd20);
    repeat (5) drive(0, 0, 0, 1, 7'd0);
    drive(0, 1, 0, 1, 7'd100);
    repeat (20) drive(0, 0, 0, 1, 7'd100);

    // Reset one cycle after a lone tick drops the in-flight read.
    repeat (4) drive(0, 0, 0, 0, 7'd0);
    drive(0, 0, 0, 1, 7'd0);
    vc0 = valid_cnt;
    drive(1, 0, 0, 0, 7'd0);
    chk("rst_abort_busy", int'(busy), 0);
    chk("rst_abort_rom_en", int'(rom_en), 0);
    repeat (5) drive(0, 0, 0, 0, 7'd0);
    chk("rst_abort_no_valid", valid_cnt - vc0, 0);

    // Random traffic.
    for (int i = 0; i < 2000; i++)
      drive(($urandom % 300) == 0, ($urandom % 20) == 0, ($urandom % 40) == 0,
            ($urandom % 3) != 0, (($urandom % 8) == 0) ? 7'd0 : 7'($urandom));
    drive(0, 0, 1, 0, 7'd0);
    drain_to_idle();
    chk("scoreboard_empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
